// File: rtl/dma_if_pcie_us_wr_desc_arb.sv
// rtl/dma_if_pcie_us_wr_desc_arb.sv - shares one write-engine descriptor/status interface among PORTS requesters
// Define DMA_WR_DESC_ARB_RR_EN for round-robin arbitration; otherwise lowest eligible index wins.
module dma_if_pcie_us_wr_desc_arb #(
  parameter int PORTS           = 4,
  parameter int PCIE_ADDR_WIDTH = 64,
  parameter int S_RAM_SEL_WIDTH = 2,
  parameter int M_RAM_SEL_WIDTH = S_RAM_SEL_WIDTH + $clog2(PORTS),
  parameter int RAM_ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH       = 16,
  parameter int S_TAG_WIDTH     = 8,
  parameter int M_TAG_WIDTH     = S_TAG_WIDTH + $clog2(PORTS),
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [PORTS*PCIE_ADDR_WIDTH-1:0]     s_axis_write_desc_pcie_addr,
  input  logic [PORTS*S_RAM_SEL_WIDTH-1:0]     s_axis_write_desc_ram_sel,
  input  logic [PORTS*RAM_ADDR_WIDTH-1:0]      s_axis_write_desc_ram_addr,
  input  logic [PORTS*LEN_WIDTH-1:0]           s_axis_write_desc_len,
  input  logic [PORTS*S_TAG_WIDTH-1:0]         s_axis_write_desc_tag,
  input  logic [PORTS-1:0]                     s_axis_write_desc_valid,
  output logic [PORTS-1:0]                     s_axis_write_desc_ready,
  output logic [PCIE_ADDR_WIDTH-1:0]           m_axis_write_desc_pcie_addr,
  output logic [M_RAM_SEL_WIDTH-1:0]           m_axis_write_desc_ram_sel,
  output logic [RAM_ADDR_WIDTH-1:0]            m_axis_write_desc_ram_addr,
  output logic [LEN_WIDTH-1:0]                 m_axis_write_desc_len,
  output logic [M_TAG_WIDTH-1:0]               m_axis_write_desc_tag,
  output logic                                 m_axis_write_desc_valid,
  input  logic                                 m_axis_write_desc_ready,
  input  logic [M_TAG_WIDTH-1:0]               s_axis_write_desc_status_tag,
  input  logic                                 s_axis_write_desc_status_valid,
  output logic [PORTS*S_TAG_WIDTH-1:0]         m_axis_write_desc_status_tag,
  output logic [PORTS-1:0]                     m_axis_write_desc_status_valid,
  output logic [PORTS-1:0]                     port_busy
);

  localparam int PW = $clog2(PORTS);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

  logic                       m_valid_q, m_valid_d;
  logic [PCIE_ADDR_WIDTH-1:0] m_pcie_addr_q, m_pcie_addr_d;
  logic [M_RAM_SEL_WIDTH-1:0] m_ram_sel_q, m_ram_sel_d;
  logic [RAM_ADDR_WIDTH-1:0]  m_ram_addr_q, m_ram_addr_d;
  logic [LEN_WIDTH-1:0]       m_len_q, m_len_d;
  logic [M_TAG_WIDTH-1:0]     m_tag_q, m_tag_d;
  logic [CNT_WIDTH-1:0]       cnt_q [PORTS];
  logic [CNT_WIDTH-1:0]       cnt_d [PORTS];
  logic [PORTS-1:0]           st_valid_q, st_valid_d;
  logic [PORTS*S_TAG_WIDTH-1:0] st_tag_q, st_tag_d;
  logic [PORTS-1:0]           busy_q, busy_d;

  logic [PORTS-1:0] eligible;
  logic [PORTS-1:0] grant;
  logic [PW-1:0]    base;
  logic [PW-1:0]    idx;
  logic [PW-1:0]    gnt_idx;
  logic             gnt_found;
  logic             can_load;
  logic             load;
  logic [PW-1:0]    st_port;
  logic             st_port_ok;
  logic             st_hit;

`ifdef DMA_WR_DESC_ARB_RR_EN
  logic [PW-1:0] rr_q, rr_d;
  assign base = rr_q;
`else
  assign base = '0;
`endif

  always_comb begin
    eligible = '0;
    for (int i = 0; i < PORTS; i++) begin
      eligible[i] = s_axis_write_desc_valid[i] && (cnt_q[i] < MAX_CNT);
    end
  end

  // Scan from the priority base; the first eligible port in circular order wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 0; k < PORTS; k++) begin
      idx = PW'((int'(base) + k) % PORTS);
      if (!gnt_found && eligible[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  assign can_load = ~m_valid_q | m_axis_write_desc_ready;
  assign load     = can_load & gnt_found;
  assign grant    = PORTS'(gnt_found) << gnt_idx;
  assign s_axis_write_desc_ready = grant & {PORTS{can_load}};

  always_comb begin
    m_valid_d     = m_valid_q;
    m_pcie_addr_d = m_pcie_addr_q;
    m_ram_sel_d   = m_ram_sel_q;
    m_ram_addr_d  = m_ram_addr_q;
    m_len_d       = m_len_q;
    m_tag_d       = m_tag_q;
    if (load) begin
      m_valid_d     = 1'b1;
      m_pcie_addr_d = s_axis_write_desc_pcie_addr[gnt_idx*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH];
      m_ram_sel_d   = {gnt_idx, s_axis_write_desc_ram_sel[gnt_idx*S_RAM_SEL_WIDTH +: S_RAM_SEL_WIDTH]};
      m_ram_addr_d  = s_axis_write_desc_ram_addr[gnt_idx*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
      m_len_d       = s_axis_write_desc_len[gnt_idx*LEN_WIDTH +: LEN_WIDTH];
      m_tag_d       = {gnt_idx, s_axis_write_desc_tag[gnt_idx*S_TAG_WIDTH +: S_TAG_WIDTH]};
    end else if (m_valid_q && m_axis_write_desc_ready) begin
      m_valid_d = 1'b0;
    end
  end

`ifdef DMA_WR_DESC_ARB_RR_EN
  always_comb begin
    rr_d = rr_q;
    if (load) begin
      rr_d = (gnt_idx == PW'(PORTS - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end
`endif

  assign st_port = s_axis_write_desc_status_tag[M_TAG_WIDTH-1 -: PW];

  // Only a non-power-of-two port count can encode an index past the last port.
  generate
    if ((1 << PW) == PORTS) begin : g_pow2
      assign st_port_ok = 1'b1;
    end else begin : g_npow2
      assign st_port_ok = (int'(st_port) < PORTS);
    end
  endgenerate

  assign st_hit = s_axis_write_desc_status_valid & st_port_ok;

  always_comb begin
    st_valid_d = '0;
    st_tag_d   = st_tag_q;
    if (st_hit) begin
      st_valid_d[st_port] = 1'b1;
      st_tag_d[st_port*S_TAG_WIDTH +: S_TAG_WIDTH] = s_axis_write_desc_status_tag[S_TAG_WIDTH-1:0];
    end
  end

  // A completion for an idle port is forwarded but must not wrap the counter.
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s_axis_write_desc_ready[i] && s_axis_write_desc_valid[i] &&
          !(st_hit && (st_port == PW'(i)))) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end else if (st_hit && (st_port == PW'(i)) &&
                   !(s_axis_write_desc_ready[i] && s_axis_write_desc_valid[i]) &&
                   (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
      end
      busy_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q     <= 1'b0;
      m_pcie_addr_q <= '0;
      m_ram_sel_q   <= '0;
      m_ram_addr_q  <= '0;
      m_len_q       <= '0;
      m_tag_q       <= '0;
      st_valid_q    <= '0;
      st_tag_q      <= '0;
      busy_q        <= '0;
      for (int i = 0; i < PORTS; i++) begin
        cnt_q[i] <= '0;
      end
`ifdef DMA_WR_DESC_ARB_RR_EN
      rr_q <= '0;
`endif
    end else begin
      m_valid_q     <= m_valid_d;
      m_pcie_addr_q <= m_pcie_addr_d;
      m_ram_sel_q   <= m_ram_sel_d;
      m_ram_addr_q  <= m_ram_addr_d;
      m_len_q       <= m_len_d;
      m_tag_q       <= m_tag_d;
      st_valid_q    <= st_valid_d;
      st_tag_q      <= st_tag_d;
      busy_q        <= busy_d;
      for (int i = 0; i < PORTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
`ifdef DMA_WR_DESC_ARB_RR_EN
      rr_q <= rr_d;
`endif
    end
  end

  assign m_axis_write_desc_valid        = m_valid_q;
  assign m_axis_write_desc_pcie_addr    = m_pcie_addr_q;
  assign m_axis_write_desc_ram_sel      = m_ram_sel_q;
  assign m_axis_write_desc_ram_addr     = m_ram_addr_q;
  assign m_axis_write_desc_len          = m_len_q;
  assign m_axis_write_desc_tag          = m_tag_q;
  assign m_axis_write_desc_status_valid = st_valid_q;
  assign m_axis_write_desc_status_tag   = st_tag_q;
  assign port_busy                      = busy_q;

endmodule
